// File: rtl/rsa_ram_pkg.sv
// Shared encodings for the RSA RAM port-A arbiter: FSM states, requester IDs, RAM RW levels,
// and the round-robin pick used by the arbiter.
package rsa_ram_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_ARB    = 2'd0;
    localparam arb_state_t ST_LOCKED = 2'd1;
    localparam arb_state_t ST_FORCE  = 2'd2;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_RSA = 1'b1;

    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;

    // On a tie the requester that did not win last time gets the port.
    function automatic logic rr_winner(input logic i_cpu, input logic i_rsa, input logic i_last);
        if (i_cpu && i_rsa) begin
            return ~i_last;
        end else if (i_rsa) begin
            return REQ_RSA;
        end
        return REQ_CPU;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tracker: a DEPTH-deep valid+tag shift register that marks which requester
// owns the RAM read data arriving DEPTH cycles after the grant.
module rd_tag_pipe
    import rsa_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_push,
    input  logic i_tag,
    output logic o_cpu_vld,
    output logic o_rsa_vld
);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_tag;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld <= '0;
            r_tag <= '0;
        end else begin
            r_vld[0] <= i_push;
            r_tag[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_cpu_vld = r_vld[DEPTH-1] && (r_tag[DEPTH-1] == REQ_CPU);
    assign o_rsa_vld = r_vld[DEPTH-1] && (r_tag[DEPTH-1] == REQ_RSA);

endmodule

// File: rtl/rsa_ram_arbiter.sv
// Port-A arbiter for the operand/result RAM: CPU vs RSA engine, round-robin with an RSA
// burst lock guarded by a watchdog, and tagged fixed-latency read return.
module rsa_ram_arbiter
    import rsa_ram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned LOCK_MAX = 256
) (
    input  logic              i_pclk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_rsa_req,
    input  logic              i_rsa_we,
    input  logic [ADDR_W-1:0] i_rsa_addr,
    input  logic [DATA_W-1:0] i_rsa_wdata,
    input  logic              i_rsa_lock,
    output logic              o_rsa_gnt,
    output logic              o_rsa_rvalid,
    output logic [DATA_W-1:0] o_rsa_rdata,
    output logic [DATA_W-1:0] o_ram_din,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_rw,
    output logic              o_ram_blk,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic              o_lock_timeout
);

    localparam int unsigned      CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_timeout;
    logic              w_timeout_set;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_rsa_rdata;

    logic w_cpu_ok;
    logic w_rsa_ok;
    logic w_any;
    logic w_win;
    logic w_push;
    logic w_cpu_vld;
    logic w_rsa_vld;

    // Grants are masked during reset so that every output shows its reset value at once.
    always_comb begin
        w_cpu_ok   = i_cpu_req && !i_reset && (r_state != ST_LOCKED);
        w_rsa_ok   = i_rsa_req && !i_reset;
        w_any      = w_cpu_ok || w_rsa_ok;
        w_win      = rr_winner(w_cpu_ok, w_rsa_ok, r_last);
        o_cpu_gnt  = w_any && (w_win == REQ_CPU);
        o_rsa_gnt  = w_any && (w_win == REQ_RSA);
        o_ram_blk  = ~w_any;
        o_ram_addr = '0;
        o_ram_din  = '0;
        o_ram_rw   = RAM_READ;
        if (o_cpu_gnt) begin
            o_ram_addr = i_cpu_addr;
            o_ram_din  = i_cpu_wdata;
            o_ram_rw   = i_cpu_we ? RAM_WRITE : RAM_READ;
        end else if (o_rsa_gnt) begin
            o_ram_addr = i_rsa_addr;
            o_ram_din  = i_rsa_wdata;
            o_ram_rw   = i_rsa_we ? RAM_WRITE : RAM_READ;
        end
        w_push = w_any && (o_ram_rw == RAM_READ);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_timeout_set = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (i_rsa_lock) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!i_rsa_lock) begin
                    w_state_nxt = ST_ARB;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_FORCE;
                    w_timeout_set = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_FORCE: begin
                // Lock stays ignored until the engine drops it at least once.
                if (!i_rsa_lock) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_state     <= ST_ARB;
            r_last      <= REQ_RSA;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_cpu_rdata <= '0;
            r_rsa_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
            if (w_any) begin
                r_last <= w_win;
            end
            if (o_cpu_rvalid) begin
                r_cpu_rdata <= i_ram_dout;
            end
            if (o_rsa_rvalid) begin
                r_rsa_rdata <= i_ram_dout;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .i_clk     (i_pclk),
        .i_reset   (i_reset),
        .i_push    (w_push),
        .i_tag     (w_win),
        .o_cpu_vld (w_cpu_vld),
        .o_rsa_vld (w_rsa_vld)
    );

    assign o_cpu_rvalid   = w_cpu_vld && !i_reset;
    assign o_rsa_rvalid   = w_rsa_vld && !i_reset;
    assign o_cpu_rdata    = o_cpu_rvalid ? i_ram_dout : r_cpu_rdata;
    assign o_rsa_rdata    = o_rsa_rvalid ? i_ram_dout : r_rsa_rdata;
    assign o_lock_timeout = r_timeout;

endmodule

// File: tb/tb_rsa_ram_arbiter.sv
// Directed bench for rsa_ram_arbiter: u_dut1 uses RD_LAT=1/LOCK_MAX=256, u_dut2 uses
// RD_LAT=3/LOCK_MAX=8; both share stimulus and each has its own RAM model.
module tb_rsa_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        reset, mem_init;
    logic        cpu_req, cpu_we, rsa_req, rsa_we, rsa_lock;
    logic [6:0]  cpu_addr, rsa_addr;
    logic [31:0] cpu_wdata, rsa_wdata;

    logic        c_gnt1, c_rv1, r_gnt1, r_rv1, rw1, blk1, to1;
    logic [31:0] c_rd1, r_rd1, din1, dout1;
    logic [6:0]  addr1;
    logic        c_gnt2, c_rv2, r_gnt2, r_rv2, rw2, blk2, to2;
    logic [31:0] c_rd2, r_rd2, din2, dout2;
    logic [6:0]  addr2;

    rsa_ram_arbiter #(.ADDR_W(7), .DATA_W(32), .RD_LAT(1), .LOCK_MAX(256)) u_dut1 (
        .i_pclk(clk), .i_reset(reset),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(c_gnt1), .o_cpu_rvalid(c_rv1), .o_cpu_rdata(c_rd1),
        .i_rsa_req(rsa_req), .i_rsa_we(rsa_we), .i_rsa_addr(rsa_addr), .i_rsa_wdata(rsa_wdata),
        .i_rsa_lock(rsa_lock), .o_rsa_gnt(r_gnt1), .o_rsa_rvalid(r_rv1), .o_rsa_rdata(r_rd1),
        .o_ram_din(din1), .o_ram_addr(addr1), .o_ram_rw(rw1), .o_ram_blk(blk1),
        .i_ram_dout(dout1), .o_lock_timeout(to1)
    );

    rsa_ram_arbiter #(.ADDR_W(7), .DATA_W(32), .RD_LAT(3), .LOCK_MAX(8)) u_dut2 (
        .i_pclk(clk), .i_reset(reset),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(c_gnt2), .o_cpu_rvalid(c_rv2), .o_cpu_rdata(c_rd2),
        .i_rsa_req(rsa_req), .i_rsa_we(rsa_we), .i_rsa_addr(rsa_addr), .i_rsa_wdata(rsa_wdata),
        .i_rsa_lock(rsa_lock), .o_rsa_gnt(r_gnt2), .o_rsa_rvalid(r_rv2), .o_rsa_rdata(r_rd2),
        .o_ram_din(din2), .o_ram_addr(addr2), .o_ram_rw(rw2), .o_ram_blk(blk2),
        .i_ram_dout(dout2), .o_lock_timeout(to2)
    );

    // RAM models: word i initialised to i, read data delayed by the DUT's RD_LAT.
    logic [31:0] mem1 [128];
    logic [31:0] mem2 [128];
    logic [31:0] p2 [3];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem1[i] <= 32'(i);
            dout1 <= '0;
        end else begin
            dout1 <= '0;
            if (!blk1) begin
                if (rw1) dout1 <= mem1[addr1];
                else     mem1[addr1] <= din1;
            end
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem2[i] <= 32'(i);
            for (int i = 0; i < 3; i++) p2[i] <= '0;
        end else begin
            p2[0] <= '0;
            p2[1] <= p2[0];
            p2[2] <= p2[1];
            if (!blk2) begin
                if (rw2) p2[0] <= mem2[addr2];
                else     mem2[addr2] <= din2;
            end
        end
    end
    assign dout2 = p2[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        rsa_req = 0; rsa_we = 0; rsa_addr = '0; rsa_wdata = '0;
        rsa_lock = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        tick();
        reset = 0;
    endtask

    initial begin
        mem_init = 1;
        reset = 1;
        idle();
        tick();
        tick();
        mem_init = 0;

        // Reset values
        smp();
        chk("rst_cpu_gnt", c_gnt1, 0);
        chk("rst_rsa_gnt", r_gnt1, 0);
        chk("rst_blk", blk1, 1);
        chk("rst_rw", rw1, 1);
        chk("rst_addr", addr1, 0);
        chk("rst_din", din1, 0);
        chk("rst_cpu_rv", c_rv1, 0);
        chk("rst_rsa_rv", r_rv1, 0);
        chk("rst_to1", to1, 0);
        chk("rst_to2", to2, 0);
        tick();

        // Test 1: CPU write granted in the request cycle
        reset = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'h05; cpu_wdata = 32'hDEADBEEF;
        smp();
        chk("t1_cpu_gnt", c_gnt1, 1);
        chk("t1_rsa_gnt", r_gnt1, 0);
        chk("t1_blk", blk1, 0);
        chk("t1_rw", rw1, 0);
        chk("t1_addr", addr1, 7'h05);
        chk("t1_din", din1, 32'hDEADBEEF);
        tick();
        idle();
        smp();
        chk("t1_no_rv", c_rv1, 0);
        chk("t1_idle_blk", blk1, 1);
        tick();

        // Test 2: both read continuously, grants alternate starting with CPU
        do_reset();
        cpu_req = 1; cpu_addr = 7'h10;
        rsa_req = 1; rsa_addr = 7'h20;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("t2_cpu_gnt", c_gnt1, (k % 2 == 0));
            chk("t2_rsa_gnt", r_gnt1, (k % 2 == 1));
            chk("t2_addr", addr1, (k % 2 == 0) ? 7'h10 : 7'h20);
            chk("t2_cpu_rv", c_rv1, (k % 2 == 1));
            chk("t2_rsa_rv", r_rv1, (k >= 2 && k % 2 == 0));
            if (k >= 1 && k % 2 == 1) chk("t2_cpu_rdata", c_rd1, 32'h10);
            if (k >= 2 && k % 2 == 0) chk("t2_rsa_rdata", r_rd1, 32'h20);
            tick();
        end

        // Test 3: 10-cycle lock, CPU shut out until ARB is re-entered
        do_reset();
        cpu_req = 1; cpu_addr = 7'h10;
        rsa_req = 1; rsa_addr = 7'h20;
        for (int c = 0; c < 12; c++) begin
            rsa_lock = (c < 10);
            smp();
            chk("t3_cpu_gnt", c_gnt1, (c == 0 || c == 11));
            chk("t3_rsa_gnt", r_gnt1, !(c == 0 || c == 11));
            tick();
        end
        chk("t3_no_timeout", to1, 0);

        // Test 4: LOCK_MAX=8 watchdog forces release, lock ignored until it drops
        do_reset();
        cpu_req = 1; cpu_addr = 7'h10;
        rsa_req = 1; rsa_addr = 7'h20;
        for (int c = 0; c < 22; c++) begin
            rsa_lock = (c < 20);
            smp();
            chk("t4_cpu_gnt", c_gnt2, (c == 0 || (c >= 9 && c % 2 == 1)));
            chk("t4_rsa_gnt", r_gnt2, !(c == 0 || (c >= 9 && c % 2 == 1)));
            chk("t4_timeout", to2, (c >= 9));
            tick();
        end

        // Test 5: reset right after a granted read kills the return
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'h10;
        smp();
        chk("t5_to2_cleared", to2, 0);
        chk("t5_cpu_gnt", c_gnt1, 1);
        tick();
        reset = 1;
        idle();
        smp();
        chk("t5_rst_rv1", c_rv1, 0);
        chk("t5_rst_gnt", c_gnt1, 0);
        chk("t5_rst_blk", blk1, 1);
        chk("t5_rst_rw", rw1, 1);
        chk("t5_rst_addr", addr1, 0);
        chk("t5_rst_din", din1, 0);
        tick();
        reset = 0;
        for (int c = 2; c < 5; c++) begin
            smp();
            chk("t5_no_rv1", c_rv1, 0);
            chk("t5_no_rv2", c_rv2, 0);
            chk("t5_to2", to2, 0);
            tick();
        end

        // Test 6: RD_LAT=3, CPU read / RSA write / RSA read back-to-back
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c == 0) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 7'h11;
            end else if (c == 1) begin
                rsa_req = 1; rsa_we = 1; rsa_addr = 7'h30; rsa_wdata = 32'hCAFE0001;
            end else if (c == 2) begin
                rsa_req = 1; rsa_we = 0; rsa_addr = 7'h30;
            end
            smp();
            if (c == 0) chk("t6_cpu_gnt", c_gnt2, 1);
            if (c == 1) chk("t6_wr_rw", rw2, 0);
            if (c == 2) chk("t6_rd_gnt", r_gnt2, 1);
            chk("t6_cpu_rv", c_rv2, (c == 3));
            chk("t6_rsa_rv", r_rv2, (c == 5));
            if (c == 3) chk("t6_cpu_rdata", c_rd2, 32'h11);
            if (c == 5) chk("t6_rsa_rdata", r_rd2, 32'hCAFE0001);
            if (c == 6) chk("t6_cpu_hold", c_rd2, 32'h11);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
